output_ctrl_rr: RTL and testbench

//   Clocked, parametrised successor to the 4-input arbiter-tree output controller.

---
 rtl/output_ctrl_rr.sv | 91 +++++++++
 tb/tb_output_ctrl_rr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/output_ctrl_rr.sv
// Output controller: merges NUM_IN input ports onto one output port through a
// round-robin arbiter and a one-entry holding register. Define OUTCTRL_FIXED_PRIO_EN
// for fixed lowest-index-wins priority (ptr held at 0).
module output_ctrl_rr #(
  parameter int WIDTH_packet = 57,
  parameter int NUM_IN       = 4,
  parameter int IDX_W        = $clog2(NUM_IN)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_IN-1:0]              in_valid,
  output logic [NUM_IN-1:0]              in_ready,
  input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH_packet-1:0]        out_data,
  output logic [IDX_W-1:0]               out_src
);

  // state    | meaning
  // ST_EMPTY | holding register empty, out_valid low
  // ST_FULL  | holding register holds a packet for downstream
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]              state;
  logic                    load;
  logic [NUM_IN-1:0]       grant;
  logic                    any_grant;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        ptr_nxt;
  logic [WIDTH_packet-1:0] grant_data;
  int                      idx;
  logic [IDX_W-1:0]        idx_v;

  assign out_valid = (state == ST_FULL);
  assign load      = !out_valid || out_ready;

  // Search starts at ptr and wraps; first valid input found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      idx_v = IDX_W'(idx);
      if (!any_grant && in_valid[idx_v]) begin
        any_grant        = 1'b1;
        grant[idx_v]     = 1'b1;
        grant_idx        = idx_v;
      end
    end
  end

  assign grant_data = in_data[grant_idx*WIDTH_packet +: WIDTH_packet];
  assign ptr_nxt    = (grant_idx == IDX_W'(NUM_IN-1)) ? '0 : grant_idx + IDX_W'(1);
  assign in_ready   = reset ? '0 : (grant & {NUM_IN{load}});

`ifdef OUTCTRL_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load && any_grant) begin
      ptr <= ptr_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_src  <= '0;
    end else if (load) begin
      if (any_grant) begin
        state    <= ST_FULL;
        out_data <= grant_data;
        out_src  <= grant_idx;
      end else begin
        state    <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_output_ctrl_rr.sv
// Testbench for output_ctrl_rr: directed steps followed by random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_output_ctrl_rr;
  localparam int W  = 57;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;

  output_ctrl_rr #(.WIDTH_packet(W), .NUM_IN(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // stimulus state (senders) and reference model state
  bit           pv [N];
  logic [W-1:0] pd [N];
  bit           refill;
  bit           r_reset;
  bit           r_oready;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_ptr;

  function automatic void chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endfunction

  function automatic logic [W-1:0] rnd_data();
    return W'({$urandom(), $urandom()});
  endfunction

  // first valid input at or after m_ptr (wrapping), -1 if none
  function automatic int winner();
    for (int j = 0; j < N; j++) begin
      int k;
      k = (m_ptr + j) % N;
      if (pv[k]) return k;
    end
    return -1;
  endfunction

  task automatic cycle();
    int           w;
    bit           ld;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset     = r_reset;
    out_ready = r_oready;
    for (int i = 0; i < N; i++) begin
      in_valid[i]        = pv[i];
      in_data[i*W +: W]  = pd[i];
    end
    #1;
    ld      = !m_valid || r_oready;
    w       = winner();
    exp_rdy = '0;
    if (!r_reset && ld && w >= 0) exp_rdy[w] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_src", 64'(out_src), 64'(m_src));
    end
    @(posedge clk);
    if (r_reset) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = pd[w];
        m_src   = w;
`ifndef OUTCTRL_FIXED_PRIO_EN
        m_ptr   = (w + 1) % N;
`endif
        if (refill) pd[w] = rnd_data();
        else        pv[w] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; in_valid = '0; in_data = '0;
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    refill = 1'b0;
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pd[i] = rnd_data(); end

    // 1: reset with all inputs valid
    r_reset = 1'b1; r_oready = 1'b1;
    for (int i = 0; i < N; i++) pv[i] = 1'b1;
    cycle(); cycle();
    chk("reset_out_valid", 64'(out_valid), 64'(0));

    // 2: only in2 valid
    r_reset = 1'b0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    pv[2] = 1'b1; pd[2] = 57'h0AB;
    cycle();
    chk("single_data", 64'(out_data), 64'h0AB);
    chk("single_src", 64'(out_src), 64'd2);
    cycle();

    // 3: all valid continuously from a fresh reset: 0,1,2,3,... (fixed prio: 0,0,..)
    r_reset = 1'b1; cycle(); r_reset = 1'b0;
    refill = 1'b1;
    for (int i = 0; i < N; i++) pv[i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_valid", 64'(out_valid), 64'd1);
`ifdef OUTCTRL_FIXED_PRIO_EN
      chk("rr_seq", 64'(out_src), 64'd0);
`else
      chk("rr_seq", 64'(out_src), 64'(k % N));
`endif
    end
`ifdef OUTCTRL_FIXED_PRIO_EN
    pv[0] = 1'b0;
    cycle(); cycle();
    chk("fixed_drop0", 64'(out_src), 64'd1);
`endif

    // 4: stall with only in1 valid, then release
    refill = 1'b0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    pv[1] = 1'b1; pd[1] = rnd_data();
    r_oready = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    r_oready = 1'b1;
    cycle();
    chk("stall_release_src", 64'(out_src), 64'd1);
    chk("stall_release_data", 64'(out_data), 64'(m_data));

    // 5: reset during a stalled full register
    for (int i = 0; i < N; i++) begin pv[i] = 1'b1; pd[i] = rnd_data(); end
    r_oready = 1'b0;
    cycle(); cycle();
    r_reset = 1'b1;
    cycle();
    chk("reset_stall_valid", 64'(out_valid), 64'd0);
    chk("reset_stall_src", 64'(out_src), 64'd0);
    r_reset = 1'b0; r_oready = 1'b1;
    cycle();
    chk("first_after_reset", 64'(out_src), 64'd0);

    // random traffic
    refill = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r_oready = ($urandom_range(9) < 7);
      r_reset  = ($urandom_range(63) == 0);
      refill   = $urandom_range(1) == 1;
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(2) == 0) begin
          pv[i] = 1'b1; pd[i] = rnd_data();
        end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
